// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I width/sign funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - lsu_state_t: FSM state encoding
//   - lsu_fault(): illegal-funct3 / misalignment check for a request
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // A request faults when its funct3 is not a legal code for its direction,
  // or when a halfword/word access is not naturally aligned.
  function automatic logic lsu_fault(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    if (we) begin
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   word     in  memory word (little-endian)
//   byte_off in  byte offset within the word (addr[1:0])
//   funct3   in  access width/sign code
//   wdata    in  store data (low byte/half used for SB/SH)
//   rdata    out load result, sign/zero-extended per funct3 (LW passes word)
//   merged   out word with the addressed byte/half replaced by store data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       byte_off,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? word[31:16] : word[15:0];

    rdata = word;
    case (funct3)
      F3_B:    rdata = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_H:    rdata = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   rdata = {{(WIDTH-16){1'b0}}, half_sel};
      default: rdata = word;
    endcase

    merged = wdata;
    case (funct3)
      F3_B: begin
        merged = word;
        merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        merged = word;
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store engine in front of a word-wide
// data memory. Sub-word stores are done as read-modify-write.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE (and never during rst). The response is a
// single-cycle rsp_valid pulse with no back-pressure.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we, req_funct3        store flag, RV32I width/sign code
//   req_addr, req_wdata       byte address, store data
//   rsp_valid/rsp_rdata/rsp_fault  completion pulse, load data, fault flag
//   mem_A/mem_WE/mem_in_Data  word address, write enable, write word
//   mem_o_Data                combinational read word at mem_A
// The FSM state is the signal `state` (lsu_state_t) for external checkers.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_fault,
  output logic [WIDTH-1:0] mem_A,
  output logic             mem_WE,
  output logic [WIDTH-1:0] mem_in_Data,
  input  logic [WIDTH-1:0] mem_o_Data
);

  lsu_state_t       state;
  logic             we_q;
  logic             fault_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  // Holds the extended load result (loads) or the merged word (SB/SH).
  logic [WIDTH-1:0] word_q;

  logic             fault_now;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] merged_val;

  assign fault_now = lsu_fault(req_we, req_funct3, req_addr[1:0]);

  // Lane logic works on the live memory word during READ, so the result
  // captured into word_q is already what RESP or WRITE needs.
  lsu_align #(.WIDTH(WIDTH)) u_align (
    .word     (mem_o_Data),
    .byte_off (addr_q[1:0]),
    .funct3   (f3_q),
    .wdata    (wdata_q),
    .rdata    (load_val),
    .merged   (merged_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            fault_q <= fault_now;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            word_q  <= '0;
            if (fault_now)                             state <= ST_RESP;
            else if (req_we && (req_funct3 == F3_W))   state <= ST_WRITE;
            else                                       state <= ST_READ;
          end
        end
        ST_READ: begin
          word_q <= we_q ? merged_val : load_val;
          state  <= we_q ? ST_WRITE : ST_RESP;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == ST_IDLE) && !rst;
  assign rsp_valid   = (state == ST_RESP);
  assign rsp_fault   = rsp_valid && fault_q;
  assign rsp_rdata   = (rsp_valid && !we_q && !fault_q) ? word_q : '0;
  assign mem_A       = {addr_q[WIDTH-1:2], 2'b00};
  // Gating by rst keeps a WRITE cycle that coincides with reset from committing.
  assign mem_WE      = (state == ST_WRITE) && !rst;
  assign mem_in_Data = (state == ST_WRITE) ? ((f3_q == F3_W) ? wdata_q : word_q) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: word memory model, request driver,
// response scoreboard (expected queues) and a one-line final report.
module tb_load_store_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [2:0]   req_funct3;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_fault;
  logic [W-1:0] mem_A;
  logic         mem_WE;
  logic [W-1:0] mem_in_Data;
  logic [W-1:0] mem_o_Data;

  load_store_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_fault   (rsp_fault),
    .mem_A       (mem_A),
    .mem_WE      (mem_WE),
    .mem_in_Data (mem_in_Data),
    .mem_o_Data  (mem_o_Data)
  );

  // ---------------- memory model ----------------
  logic [W-1:0] mem [0:63];
  assign mem_o_Data = mem[mem_A[7:2]];
  always @(posedge clk) if (mem_WE) mem[mem_A[7:2]] <= mem_in_Data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_f_q[$];
  int           acc_q[$];
  int           lat_q[$];
  string        tag_q[$];
  int we_count    = 0;
  int last_we_cyc = -1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [W-1:0] m_rd;
  logic         m_f;
  int           m_acc;
  int           m_lat;
  string        m_tag;

  always @(negedge clk) begin
    if (mem_WE) begin
      we_count    = we_count + 1;
      last_we_cyc = cyc;
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        m_rd  = exp_q.pop_front();
        m_f   = exp_f_q.pop_front();
        m_acc = acc_q.pop_front();
        m_lat = lat_q.pop_front();
        m_tag = tag_q.pop_front();
        check({m_tag, "_rdata"}, rsp_rdata, m_rd);
        check({m_tag, "_fault"}, 32'(rsp_fault), 32'(m_f));
        check({m_tag, "_latency"}, 32'(cyc - m_acc), 32'(m_lat));
      end
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [W-1:0] ref_byte(input logic [W-1:0] w, input int lane, input bit sgn);
    logic [7:0] b;
    b = 8'((w >> (8 * lane)) & 32'hFF);
    return sgn ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  function automatic logic [W-1:0] ref_half(input logic [W-1:0] w, input int hi, input bit sgn);
    logic [15:0] h;
    h = hi ? w[31:16] : w[15:0];
    return sgn ? {{16{h[15]}}, h} : {16'h0, h};
  endfunction

  // ---------------- driver ----------------
  // Called at/just after a falling edge. Waits for acceptance, then for the
  // response to drain; also checks how many write cycles the request caused
  // and, for stores, in which cycle the write happened.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [W-1:0] addr,
                        input logic [W-1:0] wd, input logic [W-1:0] exp_rd,
                        input logic exp_f, input int lat, input string tag);
    int k;
    int wc0;
    bit ok;
    k   = 0;
    ok  = 1'b0;
    wc0 = we_count;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (req_ready) begin
        ok = 1'b1;
        k  = cyc;
        exp_q.push_back(exp_rd);
        exp_f_q.push_back(exp_f);
        acc_q.push_back(k);
        lat_q.push_back(lat);
        tag_q.push_back(tag);
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!ok) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_rsp_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete(); exp_f_q.delete(); acc_q.delete(); lat_q.delete(); tag_q.delete();
    end
    check({tag, "_we_count"}, 32'(we_count - wc0), (we && !exp_f) ? 32'd1 : 32'd0);
    if (we && !exp_f) check({tag, "_we_cycle"}, 32'(last_we_cyc), 32'(k + lat - 1));
  endtask

  // ---------------- main sequence ----------------
  logic [W-1:0] rnd_addr;
  logic [W-1:0] rnd_data;
  int           lane;
  int           hsel;
  int           k0;
  int           wc_rst;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'h808182F3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_req_ready",   32'(req_ready), 32'd1);
    check("rst_rsp_valid",   32'(rsp_valid), 32'd0);
    check("rst_rsp_fault",   32'(rsp_fault), 32'd0);
    check("rst_rsp_rdata",   rsp_rdata, 32'd0);
    check("rst_mem_WE",      32'(mem_WE), 32'd0);
    check("rst_mem_A",       mem_A, 32'd0);
    check("rst_mem_in_Data", mem_in_Data, 32'd0);

    // Loads from the preloaded word
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, "lb_13");
    do_req(1'b0, 3'b100, 32'h11, 32'h0, 32'h00000082, 1'b0, 2, "lbu_11");
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8081, 1'b0, 2, "lh_12");
    do_req(1'b0, 3'b101, 32'h10, 32'h0, 32'h000082F3, 1'b0, 2, "lhu_10");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h808182F3, 1'b0, 2, "lw_10");

    // Sub-word stores by read-modify-write
    do_req(1'b1, 3'b000, 32'h11, 32'h123456AB, 32'h0, 1'b0, 3, "sb_11");
    check("mem_after_sb", mem[4], 32'h8081ABF3);
    do_req(1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0, 1'b0, 3, "sh_12");
    check("mem_after_sh", mem[4], 32'hCAFEABF3);

    // Faults: misaligned and illegal funct3
    do_req(1'b1, 3'b010, 32'h22, 32'hDEADBEEF, 32'h0, 1'b1, 1, "sw_22_mis");
    do_req(1'b0, 3'b001, 32'h13, 32'h0,        32'h0, 1'b1, 1, "lh_13_mis");
    do_req(1'b0, 3'b011, 32'h10, 32'h0,        32'h0, 1'b1, 1, "ld_f3_011");
    do_req(1'b1, 3'b100, 32'h10, 32'h55555555, 32'h0, 1'b1, 1, "st_f3_100");
    check("mem10_after_faults", mem[4], 32'hCAFEABF3);
    check("mem20_after_faults", mem[8], 32'h0);

    // Random SW followed by sub-word loads of the same word
    for (int i = 0; i < 6; i++) begin
      rnd_addr = 32'h40 + 32'(4 * $urandom_range(0, 15));
      rnd_data = $urandom;
      lane     = $urandom_range(0, 3);
      hsel     = $urandom_range(0, 1);
      do_req(1'b1, 3'b010, rnd_addr, rnd_data, 32'h0, 1'b0, 2, "rnd_sw");
      check("rnd_mem", mem[rnd_addr[7:2]], rnd_data);
      do_req(1'b0, 3'b000, rnd_addr + 32'(lane), 32'h0,
             ref_byte(rnd_data, lane, 1'b1), 1'b0, 2, "rnd_lb");
      do_req(1'b0, 3'b100, rnd_addr + 32'(lane), 32'h0,
             ref_byte(rnd_data, lane, 1'b0), 1'b0, 2, "rnd_lbu");
      do_req(1'b0, 3'b001, rnd_addr + 32'(2 * hsel), 32'h0,
             ref_half(rnd_data, hsel, 1'b1), 1'b0, 2, "rnd_lh");
    end

    // Reset landing on the WRITE cycle of an SH
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h10;
    req_wdata  = 32'h00001234;
    check("rstw_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstw_in_write", 32'(mem_WE), 32'd1);
    wc_rst = we_count;
    rst = 1'b1;
    #1;
    check("rstw_we_gated",   32'(mem_WE), 32'd0);
    check("rstw_ready_low",  32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw_ready_after", 32'(req_ready), 32'd1);
    check("rstw_mem_A",       mem_A, 32'd0);
    repeat (4) @(negedge clk);
    check("rstw_mem_unchanged", mem[4], 32'hCAFEABF3);
    check("rstw_no_more_we",    32'(we_count - wc_rst), 32'd0);

    // Back-to-back LWs with req_valid held high
    @(negedge clk);
    #1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    k0 = cyc;
    check("b2b_ready_k0", 32'(req_ready), 32'd1);
    exp_q.push_back(32'hCAFEABF3); exp_f_q.push_back(1'b0);
    acc_q.push_back(k0);           lat_q.push_back(2); tag_q.push_back("b2b_first");
    exp_q.push_back(32'hCAFEABF3); exp_f_q.push_back(1'b0);
    acc_q.push_back(k0 + 3);       lat_q.push_back(2); tag_q.push_back("b2b_second");
    @(negedge clk); #1;
    check("b2b_ready_read", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check("b2b_ready_resp", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check("b2b_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk); #1;
    req_valid = 1'b0;
    check("b2b_ready_busy2", 32'(req_ready), 32'd0);
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side companion to the byte-addressed data memory. Accepts one load or store at a time from the core's memory stage. Drives the memory's word-aligned address, write-enable and write-data ports. Returns sign- or zero-extended load data, or completes sub-word stores by read-modify-write, because the memory only writes whole 32-bit words.

## Interface
Parameters:
- WIDTH, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data (low byte/half used for SB/SH)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  WIDTH  load result; 0 for stores and faults
- rsp_fault  out  1  valid with rsp_valid: misaligned or illegal funct3
- mem_A  out  WIDTH  word address to memory, low 2 bits always 0
- mem_WE  out  1  memory write enable
- mem_in_Data  out  WIDTH  word written to memory
- mem_o_Data  in  WIDTH  combinational read word at mem_A

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr, wdata. Then:
    - fault → RESP
    - load → READ
    - SW → WRITE
    - SB/SH → READ
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is a fault.
- Misaligned: H with addr[0]=1; W with addr[1:0]≠0. Byte accesses never misalign.
- READ:
  - Capture mem_o_Data into word register.
  - Load → RESP; SB/SH → WRITE.
- WRITE:
  - mem_WE=1.
  - mem_in_Data is either:
    - wdata (SW), or
    - captured word with lane replaced: SB lane addr[1:0] gets wdata[7:0]; SH half addr[1] gets wdata[15:0].
  - Next state RESP.
- RESP:
  - rsp_valid=1, rsp_fault as latched → IDLE.
  - No back-pressure on responses.
- Load extraction (little-endian):
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU. LW passes the word.
- mem_A = {addr_q[WIDTH-1:2],2'b00} from the latched address in all states.
- Faulting requests never assert mem_WE.

## Timing
- Request accepted at edge N (req_valid && req_ready). Response cycles:
  - Fault: rsp_valid in cycle N+1.
  - Load: READ N+1, rsp_valid N+2.
  - SW: WRITE N+1 (memory commits at edge ending N+1), rsp_valid N+2.
  - SB/SH: READ N+1, WRITE N+2, rsp_valid N+3.
- Next request accepted at earliest in the cycle after RESP. req_ready=0 in READ/WRITE/RESP.
- mem_WE high exactly one cycle per store.
- Reset (sampled at edge):
  - State → IDLE; all registers → 0.
  - Outputs after reset: req_ready=1; rsp_valid=0, rsp_fault=0, rsp_rdata=0, mem_WE=0, mem_A=0, mem_in_Data=0.
- Reset mid-operation:
  - In-flight request is dropped with no response.
  - mem_WE is gated by !rst, so a WRITE cycle coinciding with rst commits nothing.
  - req_ready=0 while rst is high.
- Simultaneous req_valid and rst: request not accepted.

## Structure
- lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum lsu_state_t
- Sub-module lsu_align (combinational) holds:
  - load extract/extend: word, addr[1:0], funct3 → rdata
  - store merge: word, wdata, addr[1:0], funct3 → merged word
- Top holds the FSM and registers.

## Test plan
Memory is preloaded with 0x808182F3 at 0x10.
- LB 0x13, LBU 0x11, LH 0x12, LHU 0x10, LW 0x10 → rsp_rdata 0xFFFFFF80, 0x00000082, 0xFFFF8081, 0x000082F3, 0x808182F3. Each has rsp_valid at N+2 and rsp_fault=0.
- SB 0x11 wdata 0x123456AB → mem_WE high only in N+2; word at 0x10 becomes 0x8081ABF3; rsp_valid N+3. SH 0x12 wdata 0xCAFE → word 0xCAFEABF3.
- SW 0x22 and LH 0x13 → rsp_fault=1 and rsp_rdata=0 at N+1; mem_WE never asserted; memory unchanged.
- Load funct3 011 and store funct3 100 → rsp_fault=1; no write.
- SH 0x10 with rst asserted during WRITE cycle → mem_WE=0, memory unchanged, no rsp_valid; req_ready=1 the cycle after rst drops.
- req_valid held high with two back-to-back LWs → second accepted the cycle after the first RESP; req_ready low throughout the busy interval.
